// File: rtl/frac_div_pkg.sv
// Shared types and helpers for the fractional divider scheduler.
package frac_div_pkg;

    localparam int CNT_W   = 8;
    localparam int FRAC_W  = 8;
    localparam int MIN_INT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0]  ival;
        logic [FRAC_W-1:0] num;
        logic [FRAC_W-1:0] den;
    } cfg_t;

    // A ratio is usable only if INT >= 2 and NUM/DEN is a proper fraction.
    function automatic logic cfg_legal(input cfg_t c);
        return (c.ival >= CNT_W'(MIN_INT)) && (c.den != '0) && (c.num < c.den);
    endfunction

endpackage

// File: rtl/frac_phase_acc.sv
// Phase accumulator: decides whether the next output period is long (INT+1).
module frac_phase_acc
    import frac_div_pkg::*;
#(
    parameter int W = FRAC_W
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         step_i,
    input  logic         clear_i,
    input  logic [W-1:0] num_i,
    input  logic [W-1:0] den_i,
    output logic         long_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] base;
    logic [W:0]   sum;

    // Clear forces a zero base so a freshly applied ratio starts from phase 0.
    always_comb begin
        base   = clear_i ? '0 : acc_q;
        sum    = {1'b0, base} + {1'b0, num_i};
        long_o = (sum >= {1'b0, den_i});
        acc_d  = acc_q;
        if (step_i) begin
            acc_d = long_o ? W'(sum - {1'b0, den_i}) : W'(sum);
        end else if (clear_i) begin
            acc_d = '0;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/frac_div_sched.sv
// Fractional clock-divider scheduler: FSM, config/shadow registers, period counter, clk_out.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped, clk_out low; waits for enable with a loaded ratio
// RUN   | generating periods; cnt walks 0..L-1
// DRAIN | enable dropped; finishing the current period
module frac_div_sched
    import frac_div_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_num,
    input  logic [FRAC_W-1:0] cfg_den,
    input  logic              enable,
    output logic              clk_out,
    output logic              period_start,
    output logic              sel_long,
    output logic              busy,
    output logic              cfg_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [CNT_W:0]   len_q, len_d, half;
    logic             clk_out_q, clk_out_d;
    logic             period_start_q, period_start_d;
    logic             sel_long_q, sel_long_d;
    logic             busy_q, busy_d;
    logic             cfg_err_q, cfg_err_d;
    cfg_t             act_q, act_d, shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             loaded_q, loaded_d;

    cfg_t             cfg_in, step_cfg;
    logic             cfg_fire, cfg_ok;
    logic             last, idle_go, boundary, apply, acc_clear, acc_long;

    assign cfg_in    = {cfg_int, cfg_num, cfg_den};
    assign cfg_ready = (state_q == IDLE) || !pend_q;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_ok    = cfg_legal(cfg_in);

    assign cnt_nxt = cnt_q + 1'b1;
    assign last    = ({1'b0, cnt_q} == (len_q - {{CNT_W{1'b0}}, 1'b1}));
    assign half    = (len_q + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    // A start is held off while a config lands in IDLE so the new ratio is the one used.
    assign idle_go   = (state_q == IDLE) && enable && loaded_q && !pend_q && !cfg_fire;
    assign boundary  = idle_go || ((state_q != IDLE) && last && enable);
    assign apply     = boundary && pend_q;
    assign acc_clear = apply || ((state_q == IDLE) && (pend_q || (cfg_fire && cfg_ok)));
    assign step_cfg  = apply ? shd_q : act_q;

    frac_phase_acc #(.W(FRAC_W)) u_acc (
        .clk_in  (clk_in),
        .rst     (rst),
        .step_i  (boundary),
        .clear_i (acc_clear),
        .num_i   (step_cfg.num),
        .den_i   (step_cfg.den),
        .long_o  (acc_long)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        clk_out_d      = 1'b0;
        period_start_d = 1'b0;
        sel_long_d     = sel_long_q;
        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                sel_long_d = 1'b0;
                if (idle_go) begin
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (last) begin
                    if (enable) begin
                        state_d = RUN;
                    end else begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        sel_long_d = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_nxt;
                    clk_out_d = ({1'b0, cnt_nxt} < half);
                    state_d   = enable ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (boundary) begin
            cnt_d          = '0;
            len_d          = {1'b0, step_cfg.ival} + {{CNT_W{1'b0}}, acc_long};
            sel_long_d     = acc_long;
            clk_out_d      = 1'b1;
            period_start_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    // Active/shadow config bookkeeping; illegal offers are acknowledged but dropped.
    always_comb begin
        act_d     = act_q;
        shd_d     = shd_q;
        pend_d    = pend_q;
        loaded_d  = loaded_q;
        cfg_err_d = cfg_fire && !cfg_ok;
        if (state_q == IDLE) begin
            if (pend_q) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end
            if (cfg_fire && cfg_ok) begin
                act_d    = cfg_in;
                loaded_d = 1'b1;
            end
        end else begin
            if (apply) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end
            if (cfg_fire && cfg_ok) begin
                shd_d  = cfg_in;
                pend_d = 1'b1;
            end
        end
    end

    // State, counter, config and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            clk_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            sel_long_q     <= 1'b0;
            busy_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            act_q          <= '0;
            shd_q          <= '0;
            pend_q         <= 1'b0;
            loaded_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            clk_out_q      <= clk_out_d;
            period_start_q <= period_start_d;
            sel_long_q     <= sel_long_d;
            busy_q         <= busy_d;
            cfg_err_q      <= cfg_err_d;
            act_q          <= act_d;
            shd_q          <= shd_d;
            pend_q         <= pend_d;
            loaded_q       <= loaded_d;
        end
    end

    assign clk_out      = clk_out_q;
    assign period_start = period_start_q;
    assign sel_long     = sel_long_q;
    assign busy         = busy_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_frac_div_sched.sv
// Directed bench for the fractional divider scheduler.
module tb_frac_div_sched;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_int = 8'd0;
    logic [7:0] cfg_num = 8'd0;
    logic [7:0] cfg_den = 8'd1;
    logic       enable = 1'b0;
    logic       clk_out;
    logic       period_start;
    logic       sel_long;
    logic       busy;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    frac_div_sched dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_int      (cfg_int),
        .cfg_num      (cfg_num),
        .cfg_den      (cfg_den),
        .enable       (enable),
        .clk_out      (clk_out),
        .period_start (period_start),
        .sel_long     (sel_long),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Offers one config for one cycle; returns in the cycle after the transfer edge.
    task automatic offer_cfg(input logic [7:0] i, input logic [7:0] n, input logic [7:0] d);
        cfg_int   = i;
        cfg_num   = n;
        cfg_den   = d;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ps(output bit ok);
        int n;
        n = 0;
        while (period_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ok = (period_start === 1'b1);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        enable    = 1'b1;
        cfg_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({clk_out, period_start, sel_long, busy, cfg_err} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=00000", {clk_out, period_start, sel_long, busy, cfg_err});
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", cfg_ready);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({busy, clk_out, period_start} !== 3'b000) begin
                errors++;
                $display("FAIL reset_no_cfg_idle cyc%0d got=%b exp=000", k, {busy, clk_out, period_start});
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_frac_2_1_3();
        logic [13:0] ec;
        logic [13:0] ep;
        logic [13:0] es;
        ec = 14'b10101101010110;
        ep = 14'b10101001010100;
        es = 14'b00001110000111;
        apply_reset();
        offer_cfg(8'd2, 8'd1, 8'd3);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 14; k++) begin
            checks++;
            if ({clk_out, period_start, sel_long} !== {ec[13-k], ep[13-k], es[13-k]}) begin
                errors++;
                $display("FAIL frac213 cyc%0d got=%b exp=%b", k,
                         {clk_out, period_start, sel_long}, {ec[13-k], ep[13-k], es[13-k]});
            end
            tick();
        end
    endtask

    task automatic test_int4();
        logic [11:0] ec;
        logic [11:0] ep;
        ec = 12'b110011001100;
        ep = 12'b100010001000;
        apply_reset();
        offer_cfg(8'd4, 8'd0, 8'd1);
        checks++;
        if ({busy, clk_out, period_start} !== 3'b000) begin
            errors++;
            $display("FAIL int4_pre_enable got=%b exp=000", {busy, clk_out, period_start});
        end
        enable = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if ({clk_out, period_start, sel_long, busy} !== {ec[11-k], ep[11-k], 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL int4 cyc%0d got=%b exp=%b", k,
                         {clk_out, period_start, sel_long, busy}, {ec[11-k], ep[11-k], 1'b0, 1'b1});
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [7:0] bi [3];
        logic [7:0] bn [3];
        logic [7:0] bd [3];
        logic [7:0] ec;
        logic [7:0] ep;
        bit ok;
        bi = '{8'd1, 8'd4, 8'd4};
        bn = '{8'd0, 8'd0, 8'd5};
        bd = '{8'd1, 8'd0, 8'd5};
        ec = 8'b11001100;
        ep = 8'b10001000;
        for (int t = 0; t < 3; t++) begin
            offer_cfg(bi[t], bn[t], bd[t]);
            checks++;
            if ({cfg_err, cfg_ready} !== 2'b11) begin
                errors++;
                $display("FAIL illegal%0d_err_pulse got=%b exp=11", t, {cfg_err, cfg_ready});
            end
            tick();
            checks++;
            if (cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL illegal%0d_err_clear got=%b exp=0", t, cfg_err);
            end
            wait_ps(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL illegal%0d_sync got=timeout exp=period_start", t);
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if ({clk_out, period_start, sel_long, cfg_ready} !== {ec[7-k], ep[7-k], 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL illegal%0d_ratio cyc%0d got=%b exp=%b", t, k,
                             {clk_out, period_start, sel_long, cfg_ready}, {ec[7-k], ep[7-k], 1'b0, 1'b1});
                end
                tick();
            end
        end
    endtask

    task automatic test_switch();
        logic [12:0] ec;
        logic [12:0] ep;
        logic [12:0] er;
        ec = 13'b1101110011100;
        ep = 13'b1001000010000;
        er = 13'b0001111111111;
        apply_reset();
        offer_cfg(8'd3, 8'd0, 8'd1);
        enable = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({clk_out, period_start, cfg_ready} !== 3'b001) begin
            errors++;
            $display("FAIL switch_last_cycle got=%b exp=001", {clk_out, period_start, cfg_ready});
        end
        cfg_int   = 8'd5;
        cfg_num   = 8'd0;
        cfg_den   = 8'd1;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 13; k++) begin
            checks++;
            if ({clk_out, period_start, cfg_ready} !== {ec[12-k], ep[12-k], er[12-k]}) begin
                errors++;
                $display("FAIL switch cyc%0d got=%b exp=%b", k,
                         {clk_out, period_start, cfg_ready}, {ec[12-k], ep[12-k], er[12-k]});
            end
            tick();
        end
    endtask

    task automatic test_drain();
        logic [4:0] ec;
        logic [4:0] eb;
        logic [3:0] rc;
        logic [3:0] rp;
        bit ok;
        ec = 5'b10000;
        eb = 5'b11100;
        rc = 4'b0011;
        rp = 4'b0010;
        wait_ps(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_sync got=timeout exp=period_start");
        end
        checks++;
        if (clk_out !== 1'b1) begin
            errors++;
            $display("FAIL drain_cnt0 got=%b exp=1", clk_out);
        end
        tick();
        checks++;
        if (clk_out !== 1'b1) begin
            errors++;
            $display("FAIL drain_cnt1 got=%b exp=1", clk_out);
        end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({clk_out, busy, period_start} !== {ec[4-k], eb[4-k], 1'b0}) begin
                errors++;
                $display("FAIL drain cyc%0d got=%b exp=%b", k,
                         {clk_out, busy, period_start}, {ec[4-k], eb[4-k], 1'b0});
            end
        end
        enable = 1'b1;
        tick();
        checks++;
        if ({clk_out, period_start, busy} !== 3'b111) begin
            errors++;
            $display("FAIL restart got=%b exp=111", {clk_out, period_start, busy});
        end
        tick();
        enable = 1'b0;
        tick();
        checks++;
        if ({clk_out, busy} !== 2'b11) begin
            errors++;
            $display("FAIL redrain_cnt2 got=%b exp=11", {clk_out, busy});
        end
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({clk_out, period_start, busy} !== {rc[3-k], rp[3-k], 1'b1}) begin
                errors++;
                $display("FAIL reenable cyc%0d got=%b exp=%b", k,
                         {clk_out, period_start, busy}, {rc[3-k], rp[3-k], 1'b1});
            end
        end
    endtask

    task automatic test_mid_reset();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({clk_out, period_start, sel_long, busy, cfg_err, cfg_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL midreset got=%b exp=000001",
                     {clk_out, period_start, sel_long, busy, cfg_err, cfg_ready});
        end
        rst    = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({busy, clk_out, period_start} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_idle cyc%0d got=%b exp=000", k, {busy, clk_out, period_start});
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frac_2_1_3();
        test_int4();
        test_illegal();
        test_switch();
        test_drain();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
